operand_input_ctrl: RTL and testbench
=====================================

// Module: operand_input_ctrl
// PURPOSE
//  Input stage that feeds the calculate unit. Conditions the raw board switches and the load button.
//  Every raw input is synchronised and debounced. On a confirmed button press, the operand and opcode are
//  latched into stable registers. Outputs num1/op drive calculate; load_pulse marks each new operand set.
// PARAMETERS
//  DB_CYCLES    1_000_000  stable cycles needed to accept a new input level (10 ms @100 MHz); must be >=1
//  SYNC_STAGES  2          synchroniser flop depth on every raw input; must be >=2
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  rst         in   1  asynchronous, active-low reset
//  sw_num      in   8  raw operand switches (asynchronous)
//  sw_op       in   3  raw opcode switches (asynchronous)
//  btn_load    in   1  raw load button, active-high (asynchronous, bouncing)
//  num1        out  8  latched operand to calculate
//  op          out  3  latched opcode to calculate
//  load_pulse  out  1  one-cycle strobe in the cycle num1/op take a new value
//  busy        out  1  high while the button FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst=0, async): all sync flops, counters, num1, op, and the stable registers go to 0.
//   load_pulse=0, busy=0, FSM=IDLE. Reset mid-debounce discards all partial progress.
//  Sync: {sw_op,sw_num,btn_load} each pass through SYNC_STAGES flops. Downstream logic sees only synced values.
//  Switch debounce: the 11-bit bundle {sw_op,sw_num} has one counter sw_cnt ($clog2(DB_CYCLES+1) bits).
//   - synced bundle == sw_stable: sw_cnt <= 0.
//   - differs: sw_cnt increments. If the synced bundle changes again, sw_cnt restarts at 1.
//   - when sw_cnt reaches DB_CYCLES: sw_stable <= synced bundle and sw_cnt <= 0.
//   - counter saturates; no wrap-around.
//  Button FSM with its own counter btn_cnt; states IDLE, PRESS_WAIT, HELD, REL_WAIT:
//   IDLE       synced btn=1 -> PRESS_WAIT, btn_cnt<=1
//   PRESS_WAIT btn=0 -> IDLE (glitch rejected); btn_cnt==DB_CYCLES -> HELD, fire load
//   HELD       btn=0 -> REL_WAIT, btn_cnt<=1; holding indefinitely produces no further pulses
//   REL_WAIT   btn=1 -> HELD (release glitch rejected); btn_cnt==DB_CYCLES -> IDLE
//  Load: in the PRESS_WAIT->HELD cycle, {op,num1} <= sw_stable and load_pulse=1 for exactly that cycle.
//  Simultaneous events: if sw_stable updates in the same cycle as the load, the load captures the OLD
//   sw_stable (register value before the edge).
//  Latency: a clean button edge produces load_pulse SYNC_STAGES+DB_CYCLES cycles after the raw edge.
//   A clean switch edge reaches sw_stable after the same delay.
//  DB_CYCLES=1: one synced cycle at the new level is enough to qualify it.
//  num1/op hold their value between loads. They are never combinational from the inputs.
// CONFIGURATION
//  LIVE_UPDATE_EN defined: num1/op <= sw_stable on every cycle, so calculate follows the switches live.
//   load_pulse then fires in any cycle where sw_stable changes, and also on a confirmed button press.
//  LIVE_UPDATE_EN undefined (default): num1/op change only on a confirmed button press, as above.
// TESTING (bench uses DB_CYCLES=4, SYNC_STAGES=2)
//  Reset: rst=0 with all inputs toggling -> num1=0, op=0, load_pulse=0, busy=0; FSM IDLE after release.
//  Clean load: sw_num=8'hA5, sw_op=3'b010 held for 10 cycles, then btn_load=1 held for 20 cycles
//   -> exactly one load_pulse, 6 cycles after the btn edge; num1=8'hA5, op=3'b010.
//  Bounce: btn pulses 1/0 with 2-cycle periods for 12 cycles, then held 1
//   -> exactly one load_pulse, after the final 4 stable synced cycles.
//  Switch glitch: num stable at 8'h0F; a 3-cycle blip to 8'hFF; then press
//   -> num1=8'h0F (blip rejected).
//  Mid-op reset: rst=0 for 1 cycle while in PRESS_WAIT
//   -> no load_pulse; outputs 0; a subsequent clean press loads normally.
//  LIVE_UPDATE_EN build: switch 8'h00->8'h3C with no button
//   -> num1=8'h3C and a single load_pulse 6 cycles after the change.

Source files
------------

// File: rtl/operand_input_ctrl.sv
// Input conditioning for the calculate unit: synchronises and debounces the switches and load button,
// then latches {op,num1} on a confirmed press. Optional LIVE_UPDATE_EN makes num1/op follow the switches.
module operand_input_ctrl #(
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_num,
  input  logic [2:0] sw_op,
  input  logic       btn_load,
  output logic [7:0] num1,
  output logic [2:0] op,
  output logic       load_pulse,
  output logic       busy
);

  localparam int unsigned RAW_W = 12;
  localparam int unsigned SW_W  = 11;
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_e;

  logic [RAW_W-1:0] sync_q [SYNC_STAGES];
  logic [SW_W-1:0]  sw_sync;
  logic             btn_sync;

  logic [SW_W-1:0]  sw_stable_q, sw_stable_d;
  logic [SW_W-1:0]  sw_last_q;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d, sw_next_cnt;

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d, btn_inc;
  logic             load_c;

  logic [7:0]       num1_q, num1_d;
  logic [2:0]       op_q, op_d;
  logic             load_pulse_q, load_pulse_d;
  logic             busy_q, busy_d;

  // Synchroniser chain for {sw_op, sw_num, btn_load}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {sw_op, sw_num, btn_load};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sw_sync  = sync_q[SYNC_STAGES-1][RAW_W-1:1];
  assign btn_sync = sync_q[SYNC_STAGES-1][0];

  // Switch debounce; the count includes the current cycle so DB_CYCLES synced samples qualify a level
  always_comb begin
    sw_stable_d = sw_stable_q;
    sw_cnt_d    = sw_cnt_q;
    sw_next_cnt = '0;
    if (sw_sync == sw_stable_q) begin
      sw_cnt_d = '0;
    end else begin
      if (sw_sync != sw_last_q)     sw_next_cnt = CNT_ONE;
      else if (sw_cnt_q != DB_MAX)  sw_next_cnt = sw_cnt_q + CNT_ONE;
      else                          sw_next_cnt = sw_cnt_q;
      if (sw_next_cnt >= DB_MAX) begin
        sw_stable_d = sw_sync;
        sw_cnt_d    = '0;
      end else begin
        sw_cnt_d = sw_next_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_stable_q <= '0;
      sw_last_q   <= '0;
      sw_cnt_q    <= '0;
    end else begin
      sw_stable_q <= sw_stable_d;
      sw_last_q   <= sw_sync;
      sw_cnt_q    <= sw_cnt_d;
    end
  end

  // Button debounce FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      btn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      btn_cnt_q <= btn_cnt_d;
    end
  end

  assign btn_inc = (btn_cnt_q == DB_MAX) ? btn_cnt_q : btn_cnt_q + CNT_ONE;

  // Next-state logic; with DB_CYCLES==1 the first synced sample already qualifies
  always_comb begin
    state_d   = state_q;
    btn_cnt_d = btn_cnt_q;
    load_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          if (DB_MAX <= CNT_ONE) begin
            state_d   = HELD;
            btn_cnt_d = '0;
            load_c    = 1'b1;
          end else begin
            state_d   = PRESS_WAIT;
            btn_cnt_d = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d   = IDLE;
          btn_cnt_d = '0;
        end else if (btn_inc >= DB_MAX) begin
          state_d   = HELD;
          btn_cnt_d = '0;
          load_c    = 1'b1;
        end else begin
          btn_cnt_d = btn_inc;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          if (DB_MAX <= CNT_ONE) begin
            state_d   = IDLE;
            btn_cnt_d = '0;
          end else begin
            state_d   = REL_WAIT;
            btn_cnt_d = CNT_ONE;
          end
        end
      end
      REL_WAIT: begin
        if (btn_sync) begin
          state_d   = HELD;
          btn_cnt_d = '0;
        end else if (btn_inc >= DB_MAX) begin
          state_d   = IDLE;
          btn_cnt_d = '0;
        end else begin
          btn_cnt_d = btn_inc;
        end
      end
      default: begin
        state_d   = IDLE;
        btn_cnt_d = '0;
      end
    endcase
  end

  // Output latch: a press captures sw_stable as it was before this edge
  always_comb begin
    num1_d       = num1_q;
    op_d         = op_q;
    load_pulse_d = 1'b0;
`ifdef LIVE_UPDATE_EN
    {op_d, num1_d} = sw_stable_d;
    load_pulse_d   = load_c || (sw_stable_d != sw_stable_q);
`else
    if (load_c) {op_d, num1_d} = sw_stable_q;
    load_pulse_d = load_c;
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num1_q       <= '0;
      op_q         <= '0;
      load_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      num1_q       <= num1_d;
      op_q         <= op_d;
      load_pulse_q <= load_pulse_d;
      busy_q       <= busy_d;
    end
  end

  assign num1       = num1_q;
  assign op         = op_q;
  assign load_pulse = load_pulse_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_operand_input_ctrl.sv
// Bench for operand_input_ctrl (DB_CYCLES=4, SYNC_STAGES=2): window-based model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_operand_input_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sw_num = '0;
  logic [2:0] sw_op = '0;
  logic       btn_load = 1'b0;
  logic [7:0] num1;
  logic [2:0] op;
  logic       load_pulse;
  logic       busy;

  operand_input_ctrl #(.DB_CYCLES(DB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sw_num(sw_num), .sw_op(sw_op), .btn_load(btn_load),
    .num1(num1), .op(op), .load_pulse(load_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = 0;
  int t0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a level is accepted once the last DB synced samples agree on it
  logic [11:0] m_s1 = '0, m_s2 = '0, m_sv = '0;
  logic [11:0] m_hist [DB];
  logic [10:0] m_stable = '0, m_old = '0;
  logic        m_level = 1'b0, m_rose = 1'b0;
  logic        m_sw_all, m_all1, m_all0;
  logic [7:0]  m_num1 = '0;
  logic [2:0]  m_op = '0;
  logic        m_pulse = 1'b0, m_busy = 1'b0;

  initial for (int i = 0; i < DB; i++) m_hist[i] = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0;
      for (int i = 0; i < DB; i++) m_hist[i] = '0;
      m_stable = '0; m_level = 1'b0;
      m_num1 = '0; m_op = '0; m_pulse = 1'b0; m_busy = 1'b0;
    end else begin
      m_sv = m_s2;
      m_s2 = m_s1;
      m_s1 = {sw_op, sw_num, btn_load};
      for (int i = DB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_sv;
      m_sw_all = 1'b1; m_all1 = 1'b1; m_all0 = 1'b1;
      for (int i = 0; i < DB; i++) begin
        if (m_hist[i][11:1] != m_sv[11:1]) m_sw_all = 1'b0;
        if (m_hist[i][0] != 1'b1) m_all1 = 1'b0;
        if (m_hist[i][0] != 1'b0) m_all0 = 1'b0;
      end
      m_old  = m_stable;
      m_rose = 1'b0;
      if (m_sw_all && (m_sv[11:1] != m_stable)) m_stable = m_sv[11:1];
      if (!m_level && m_all1) begin
        m_level = 1'b1;
        m_rose  = 1'b1;
      end else if (m_level && m_all0) begin
        m_level = 1'b0;
      end
`ifdef LIVE_UPDATE_EN
      {m_op, m_num1} = m_stable;
      m_pulse = m_rose || (m_stable != m_old);
`else
      if (m_rose) {m_op, m_num1} = m_old;
      m_pulse = m_rose;
`endif
      m_busy = m_level || m_sv[0];
    end
  end

  always @(negedge clk) begin
    chk("model_num1", 32'(num1), 32'(m_num1));
    chk("model_op", 32'(op), 32'(m_op));
    chk("model_load_pulse", 32'(load_pulse), 32'(m_pulse));
    chk("model_busy", 32'(busy), 32'(m_busy));
  end

  // One clock; outputs observed at the falling edge, inputs driven 1 ns later
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (load_pulse) begin
        pulses++;
        last_pulse = cyc;
      end
      #1;
    end
  endtask

  task automatic press_release(input logic [7:0] en, input logic [2:0] eo, input string name);
    pulses = 0;
    btn_load = 1'b1;
    t0 = cyc;
    tick(12);
    chk({name, "_pulses"}, 32'(pulses), 32'd1);
    chk({name, "_latency"}, 32'(last_pulse - t0), 32'd6);
    chk({name, "_num1"}, 32'(num1), 32'(en));
    chk({name, "_op"}, 32'(op), 32'(eo));
    btn_load = 1'b0;
    tick(10);
  endtask

  initial begin
    // Reset with inputs toggling
    for (int k = 0; k < 6; k++) begin
      sw_num = 8'($urandom); sw_op = 3'($urandom); btn_load = 1'($urandom);
      tick(1);
    end
    chk("rst_num1", 32'(num1), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_pulse", 32'(load_pulse), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    sw_num = '0; sw_op = '0; btn_load = 1'b0;
    rst = 1'b1;
    tick(8);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_num1", 32'(num1), 32'd0);

`ifdef LIVE_UPDATE_EN
    pulses = 0;
    sw_num = 8'h3C;
    t0 = cyc;
    tick(12);
    chk("live_pulses", 32'(pulses), 32'd1);
    chk("live_latency", 32'(last_pulse - t0), 32'd6);
    chk("live_num1", 32'(num1), 32'h3C);
    chk("live_busy", 32'(busy), 32'd0);
`else
    // Clean load, button held 20 cycles
    sw_num = 8'hA5; sw_op = 3'b010;
    tick(10);
    pulses = 0;
    btn_load = 1'b1;
    t0 = cyc;
    tick(20);
    chk("clean_pulses", 32'(pulses), 32'd1);
    chk("clean_latency", 32'(last_pulse - t0), 32'd6);
    chk("clean_num1", 32'(num1), 32'hA5);
    chk("clean_op", 32'(op), 32'd2);
    chk("clean_busy_held", 32'(busy), 32'd1);
    btn_load = 1'b0;
    tick(10);
    chk("clean_busy_idle", 32'(busy), 32'd0);
    chk("clean_hold_num1", 32'(num1), 32'hA5);

    // Bouncing press
    sw_num = 8'h3C; sw_op = 3'd5;
    tick(10);
    pulses = 0;
    t0 = cyc;
    for (int j = 0; j < 12; j++) begin
      btn_load = (j % 2 == 0);
      tick(1);
    end
    btn_load = 1'b1;
    tick(20);
    chk("bounce_pulses", 32'(pulses), 32'd1);
    chk("bounce_latency", 32'(last_pulse - t0), 32'd18);
    chk("bounce_num1", 32'(num1), 32'h3C);
    chk("bounce_op", 32'(op), 32'd5);
    btn_load = 1'b0;
    tick(10);

    // Three-cycle switch blip is rejected
    sw_num = 8'h0F; sw_op = 3'd1;
    tick(10);
    pulses = 0;
    sw_num = 8'hFF;
    tick(3);
    sw_num = 8'h0F;
    tick(10);
    chk("glitch_no_pulse", 32'(pulses), 32'd0);
    chk("glitch_hold_num1", 32'(num1), 32'h3C);
    press_release(8'h0F, 3'd1, "glitch");

    // Switch change and press qualify on the same edge: old operand is loaded
    sw_num = 8'h55; sw_op = 3'd6;
    press_release(8'h0F, 3'd1, "simul");
    pulses = 0;
    btn_load = 1'b1;
    tick(12);
    chk("simul2_num1", 32'(num1), 32'h55);
    chk("simul2_op", 32'(op), 32'd6);
    btn_load = 1'b0;
    tick(10);

    // Blip of exactly DB cycles is accepted
    pulses = 0;
    sw_num = 8'h81;
    t0 = cyc;
    tick(1);
    btn_load = 1'b1;
    tick(3);
    sw_num = 8'h55;
    tick(10);
    chk("edge_blip_pulses", 32'(pulses), 32'd1);
    chk("edge_blip_num1", 32'(num1), 32'h81);
    btn_load = 1'b0;
    tick(10);

    // Reset while in PRESS_WAIT
    pulses = 0;
    btn_load = 1'b1;
    tick(4);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b0; btn_load = 1'b0;
    tick(1);
    chk("midrst_num1", 32'(num1), 32'd0);
    chk("midrst_op", 32'(op), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick(12);
    chk("midrst_no_pulse", 32'(pulses), 32'd0);
    chk("midrst_hold_num1", 32'(num1), 32'd0);
    sw_num = 8'hC3; sw_op = 3'd3;
    tick(10);
    press_release(8'hC3, 3'd3, "after_rst");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
